// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard/stall sequencer for the 5-stage pipeline.
// Owns the PC and IF/ID write enables and picks the ID/EX action: load, hold or bubble.
// It detects load-use hazards, runs multi-cycle EX ops with an occupancy counter,
// and flushes IF/ID for branches taken in ID.
// Optional macro HAZ_PERF_CNT_EN adds the stall_cnt_o and lu_cnt_o performance counters.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int MULTI_LAT = 4,  // total EX occupancy of a multi-cycle op, 2..16
  parameter int CNT_W     = 4   // must hold MULTI_LAT-2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] id_rs_addr_i,
  input  logic [4:0] id_rt_addr_i,
  input  logic       id_uses_rt_i,
  input  logic       id_branch_taken_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_addr_i,
  input  logic       ex_multi_i,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0] stall_cnt_o,
  output logic [15:0] lu_cnt_o,
`endif
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       idex_bubble_o,
  output logic       idex_hold_o,
  output logic       ex_done_o
);

  typedef enum logic [1:0] {RUN = 2'd0, MULTI = 2'd1} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 2);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_multi_stall, w_release, w_load_use, w_lu_eff;

  // Hazard detection terms
  always_comb begin
    w_multi_stall = ((r_state == RUN) && ex_multi_i) ||
                    ((r_state == MULTI) && (r_cnt != '0));
    w_release     = (r_state == MULTI) && (r_cnt == '0);
    w_load_use    = ex_mem_read_i && (ex_rt_addr_i != 5'd0) &&
                    ((ex_rt_addr_i == id_rs_addr_i) ||
                     (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));
    // A load-use only counts when the multi-cycle hold does not already own the pipe
    w_lu_eff      = w_load_use && !w_multi_stall && rst_n_i;
  end

  // Next-state and output decode; priority multi_stall > load_use > flush > normal
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_hold_o   = 1'b0;
    ex_done_o     = 1'b0;

    if (!rst_n_i) begin
      // Freeze the front end and feed bubbles while reset is held
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      ex_done_o = w_release;
      if (w_multi_stall) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_hold_o  = 1'b1;
      end else if (w_load_use) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (id_branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end

    case (r_state)
      RUN: begin
        if (ex_multi_i) begin
          w_state_nxt = MULTI;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      MULTI: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else             w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and occupancy counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_lu_cnt;

  // Saturating counters for front-end stall cycles and load-use cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (!pc_write_o && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_lu_eff && (r_lu_cnt != 16'hFFFF))       r_lu_cnt    <= r_lu_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign lu_cnt_o    = r_lu_cnt;
`else
  logic w_unused;
  assign w_unused = w_lu_eff;
`endif

endmodule
